// File: rtl/sprite_pos_loader_pkg.sv
// Shared definitions for the vblank sprite-position loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pos_loader_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CAPT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Number of 16-bit coordinate words fetched per frame
  localparam int NUM_SPRITE_WORDS = 6;

  // Word offsets inside the CPU-written coordinate table
  localparam logic [2:0] IDX_MX  = 3'd0;
  localparam logic [2:0] IDX_MY  = 3'd1;
  localparam logic [2:0] IDX_P1X = 3'd2;
  localparam logic [2:0] IDX_P1Y = 3'd3;
  localparam logic [2:0] IDX_P2X = 3'd4;
  localparam logic [2:0] IDX_P2Y = 3'd5;

  // Last word of the table; reaching it ends the fetch
  localparam logic [2:0] IDX_LAST = IDX_P2Y;

endpackage

// File: rtl/sprite_pos_loader_edge_det.sv
// Falling-edge detector for the active-low vertical sync.
// Latency: combinational pulse in the first cycle the input is seen low.
// Backpressure: none; one pulse per high-to-low transition.
module sprite_pos_loader_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  logic din_q;

  // Previous-cycle sample; resets high so a low input at reset exit is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= 1'b1;
    end else begin
      din_q <= din;
    end
  end

  assign fall = din_q & ~din;

endmodule

// File: rtl/sprite_pos_loader.sv
// Fetches six sprite coordinates from memory each vblank and commits them atomically.
// Latency: first request the cycle after the vsync fall; outputs update after 6x(REQ+CAPT)+COMMIT.
// Backpressure: mem_gnt low holds the request (addr stable) indefinitely; outputs never tear.
module sprite_pos_loader
  import sprite_pos_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h3F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              v_sync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       mx,
  output logic [15:0]       my,
  output logic [15:0]       p1x,
  output logic [15:0]       p1y,
  output logic [15:0]       p2x,
  output logic [15:0]       p2y,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  state_t      state;
  logic [2:0]  idx;
  logic        vs_fall;
  logic [15:0] shadow [NUM_SPRITE_WORDS];

  sprite_pos_loader_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .din   (v_sync),
    .fall  (vs_fall)
  );

  // Shadow file absorbs each word in its capture cycle; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (state == ST_CAPT) begin
      shadow[idx] <= mem_rdata;
    end
  end

  // Fetch sequencer with registered memory port, status flags and committed positions
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= IDX_MX;
      mem_req    <= 1'b0;
      mem_addr   <= BASE_ADDR;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      mx         <= '0;
      my         <= '0;
      p1x        <= '0;
      p1y        <= '0;
      p2x        <= '0;
      p2y        <= '0;
    end else begin
      frame_done <= 1'b0;

      // A frame start that arrives while still working is dropped but remembered
      if (vs_fall && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (vs_fall && enable) begin
            state    <= ST_REQ;
            idx      <= IDX_MX;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= BASE_ADDR;
          end
        end

        ST_REQ: begin
          // Request and address stay put until the arbiter grants
          if (mem_gnt) begin
            state   <= ST_CAPT;
            mem_req <= 1'b0;
          end
        end

        ST_CAPT: begin
          if (idx == IDX_LAST) begin
            state      <= ST_COMMIT;
            frame_done <= 1'b1;
          end else begin
            state    <= ST_REQ;
            idx      <= idx + 3'd1;
            mem_req  <= 1'b1;
            mem_addr <= BASE_ADDR + ADDR_W'(idx + 3'd1);
          end
        end

        ST_COMMIT: begin
          // All six positions change on the same edge so vga never sees a mixed frame
          mx    <= shadow[IDX_MX];
          my    <= shadow[IDX_MY];
          p1x   <= shadow[IDX_P1X];
          p1y   <= shadow[IDX_P1Y];
          p2x   <= shadow[IDX_P2X];
          p2y   <= shadow[IDX_P2Y];
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
